// File: rtl/rxnum_pkg.sv
// Shared ASCII constants and parser state encodings (rxnum, txnum).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rxnum_pkg;

    localparam logic [7:0] CH_NL    = 8'h0A;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_PLUS  = 8'h2B;
    localparam logic [7:0] CH_MINUS = 8'h2D;
    localparam logic [7:0] CH_0     = 8'h30;
    localparam logic [7:0] CH_A     = 8'h41;
    localparam logic [7:0] CH_a     = 8'h61;

    // One-hot so o_busy and per-state decode are single-bit tests.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'b001,
        ST_NUM     = 3'b010,
        ST_DISCARD = 3'b100
    } rx_state_t;

    // Only binary, decimal and hex are supported digit bases.
    function automatic logic radix_legal(input logic [4:0] radix);
        return (radix == 5'd2) || (radix == 5'd10) || (radix == 5'd16);
    endfunction

endpackage

// File: rtl/rxnum_if.sv
// Byte-in / number-out bundle between the uart rx byte stage and rxnum.
// Latency: n/a (wires only).
// Backpressure: none; the byte strobe is fire-and-forget.
interface rxnum_if #(
    parameter int SIZE = 8
);
    logic [7:0]      i_byte;
    logic            i_byte_valid;
    logic [SIZE-1:0] o_data;
    logic            o_valid;
    logic            o_err;
    logic            o_busy;

    modport master (
        output i_byte, i_byte_valid,
        input  o_data, o_valid, o_err, o_busy
    );

    modport slave (
        input  i_byte, i_byte_valid,
        output o_data, o_valid, o_err, o_busy
    );
endinterface

// File: rtl/ascii_digit.sv
// Decodes one ASCII char to a digit value and flags it valid for the radix.
// Latency: combinational.
// Backpressure: none.
module ascii_digit (
    input  logic [7:0] i_char,
    input  logic [4:0] i_radix,
    output logic [3:0] o_digit,
    output logic       o_is_digit
);
    import rxnum_pkg::*;

    logic in_set;

    // '0'-'9' map straight from the low nibble; 'A'-'F'/'a'-'f' low nibble is 1..6.
    always_comb begin
        in_set  = 1'b0;
        o_digit = 4'd0;
        if (i_char >= CH_0 && i_char <= CH_0 + 8'd9) begin
            in_set  = 1'b1;
            o_digit = i_char[3:0];
        end else if ((i_char >= CH_A && i_char <= CH_A + 8'd5) ||
                     (i_char >= CH_a && i_char <= CH_a + 8'd5)) begin
            in_set  = 1'b1;
            o_digit = i_char[3:0] + 4'd9;
        end
        o_is_digit = in_set && radix_legal(i_radix) && ({1'b0, o_digit} < i_radix);
    end

endmodule

// File: rtl/rxnum.sv
// Rebuilds a signed SIZE-bit integer from an ASCII "[sign]digits\n" stream.
// Latency: o_valid one cycle after the '\n' strobe.
// Backpressure: none; accepts a byte every cycle, including the o_valid cycle.
module rxnum #(
    parameter int RADIX     = 10,
    parameter int SIZE      = 8,
    parameter int LSD_FIRST = 0
) (
    input  logic   i_clk,
    input  logic   i_rst_n,
    rxnum_if.slave bus
);
    import rxnum_pkg::*;

    localparam int              MW      = SIZE + 1;
    localparam int              AW      = SIZE + 6;  // holds mag*16+15 without wrap
    localparam logic [AW-1:0]   LIM_POS = AW'((64'd1 << (SIZE - 1)) - 64'd1);
    localparam logic [AW-1:0]   LIM_NEG = AW'(64'd1 << (SIZE - 1));
    localparam logic [AW-1:0]   RAD_W   = AW'(RADIX);
    localparam logic [4:0]      RAD_5   = (RADIX == 2 || RADIX == 10 || RADIX == 16) ?
                                          5'(RADIX) : 5'd0;

    rx_state_t       state_q, state_d;
    logic [SIZE:0]   mag_q, mag_d, wt_q, wt_d;
    logic            neg_q, neg_d, ovf_q, ovf_d, any_q, any_d;
    logic            emit, emit_err;
    logic            o_valid_q, o_err_q;
    logic [SIZE-1:0] o_data_q;

    logic [3:0]      digit;
    logic            is_digit;
    logic [AW-1:0]   cur_mag, cur_wt, limit, acc, wt_mul, wt_nxt;
    logic            cur_neg, cur_ovf, cur_any, acc_over;

    ascii_digit u_digit (
        .i_char     (bus.i_byte),
        .i_radix    (RAD_5),
        .o_digit    (digit),
        .o_is_digit (is_digit)
    );

    // Frame-relative accumulation: a byte seen in IDLE starts from a clean slate.
    always_comb begin
        cur_mag  = (state_q == ST_IDLE) ? '0      : AW'(mag_q);
        cur_wt   = (state_q == ST_IDLE) ? AW'(1)  : AW'(wt_q);
        cur_neg  = (state_q == ST_IDLE) ? 1'b0    : neg_q;
        cur_ovf  = (state_q == ST_IDLE) ? 1'b0    : ovf_q;
        cur_any  = (state_q == ST_IDLE) ? 1'b0    : any_q;
        limit    = cur_neg ? LIM_NEG : LIM_POS;
        acc      = (LSD_FIRST != 0) ? cur_mag + AW'(digit) * cur_wt
                                    : cur_mag * RAD_W + AW'(digit);
        acc_over = acc > limit;
        wt_mul   = cur_wt * RAD_W;
        wt_nxt   = (wt_mul > limit + AW'(1)) ? limit + AW'(1) : wt_mul;
    end

    // Next state, accumulator updates and emit decision per received byte.
    always_comb begin
        state_d  = state_q;
        mag_d    = MW'(cur_mag);
        wt_d     = MW'(cur_wt);
        neg_d    = cur_neg;
        ovf_d    = cur_ovf;
        any_d    = cur_any;
        emit     = 1'b0;
        emit_err = 1'b0;
        if (bus.i_byte_valid) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.i_byte == CH_MINUS) begin
                        neg_d   = 1'b1;
                        state_d = ST_NUM;
                    end else if (bus.i_byte == CH_PLUS || bus.i_byte == CH_SPACE) begin
                        state_d = ST_NUM;
                    end else if (is_digit) begin
                        mag_d   = acc_over ? MW'(cur_mag) : MW'(acc);
                        ovf_d   = acc_over;
                        wt_d    = MW'(wt_nxt);
                        any_d   = 1'b1;
                        state_d = ST_NUM;
                    end else if (bus.i_byte == CH_NL) begin
                        emit     = 1'b1;
                        emit_err = 1'b1;
                    end else if (bus.i_byte != CH_CR) begin
                        state_d = ST_DISCARD;
                    end
                end
                ST_NUM: begin
                    if (is_digit) begin
                        // Overflow is sticky and freezes mag so it can never wrap.
                        mag_d = acc_over ? MW'(cur_mag) : MW'(acc);
                        ovf_d = cur_ovf | acc_over;
                        wt_d  = MW'(wt_nxt);
                        any_d = 1'b1;
                    end else if (bus.i_byte == CH_NL) begin
                        emit     = 1'b1;
                        emit_err = ovf_q | ~any_q;
                        state_d  = ST_IDLE;
                    end else if (bus.i_byte != CH_CR) begin
                        state_d = ST_DISCARD;
                    end
                end
                ST_DISCARD: begin
                    if (bus.i_byte == CH_NL) begin
                        emit     = 1'b1;
                        emit_err = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Accumulator registers for the frame in progress.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mag_q <= '0;
            wt_q  <= MW'(1);
            neg_q <= 1'b0;
            ovf_q <= 1'b0;
            any_q <= 1'b0;
        end else begin
            mag_q <= mag_d;
            wt_q  <= wt_d;
            neg_q <= neg_d;
            ovf_q <= ovf_d;
            any_q <= any_d;
        end
    end

    // Result registers: one-cycle pulse, data held until the next frame ends.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid_q <= 1'b0;
            o_err_q   <= 1'b0;
            o_data_q  <= '0;
        end else begin
            o_valid_q <= emit;
            o_err_q   <= emit & emit_err;
            if (emit) o_data_q <= emit_err ? '0 : SIZE'(neg_q ? -mag_q : mag_q);
        end
    end

    assign bus.o_valid = o_valid_q;
    assign bus.o_err   = o_err_q;
    assign bus.o_data  = o_data_q;
    assign bus.o_busy  = (state_q != ST_IDLE);

endmodule
